// File: rtl/wishbone_ram_burst.sv
// Wishbone slave RAM with configurable wait states, registered-feedback
// incrementing bursts (linear / wrap-4/8/16) and an error response for out-of-range addresses.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for stb & cyc; latches word index, bte, range flag
// WAIT   | counting down the access wait states
// BEAT   | first transfer of the cycle (ack, or err if out of range)
// BURST  | one beat per cycle while stb is held, cnt advances each beat
// GAP    | one dead cycle before accepting the next request
module wishbone_ram_burst #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   wishbone_addr_i,
   input  logic [DATA_WIDTH-1:0]   wishbone_data_i,
   input  logic                    wishbone_we_i,
   input  logic [DATA_WIDTH/8-1:0] wishbone_sel_i,
   input  logic                    wishbone_stb_i,
   input  logic                    wishbone_cyc_i,
   input  logic [2:0]              wishbone_cti_i,
   input  logic [1:0]              wishbone_bte_i,
   output logic [DATA_WIDTH-1:0]   wishbone_data_o,
   output logic                    wishbone_ack_o,
   output logic                    wishbone_err_o
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(SEL_W);
   localparam int WORDS = 1 << DEPTH_LOG2;

   localparam logic [2:0] CTI_INCR = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_BEAT,
      S_BURST,
      S_GAP
   } state_t;

   state_t                  state_q, state_d;
   logic [DEPTH_LOG2-1:0]   cnt_q, cnt_d;
   logic [1:0]              bte_q, bte_d;
   logic [3:0]              wait_q, wait_d;
   logic                    oor_q, oor_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   lane_mask;

   logic [DATA_WIDTH-1:0]   mem [0:WORDS-1];

   logic                    req;
   logic [ADDR_WIDTH-1:0]   addr_word_full;
   logic [DEPTH_LOG2-1:0]   addr_word;
   logic                    addr_oor;

   assign req            = wishbone_stb_i & wishbone_cyc_i;
   assign addr_word_full = wishbone_addr_i >> OFS;
   assign addr_word      = addr_word_full[DEPTH_LOG2-1:0];
   assign addr_oor       = |(addr_word_full >> DEPTH_LOG2);

   // Wrapping bursts only roll the low bits; the block base stays put.
   function automatic logic [DEPTH_LOG2-1:0] advance(input logic [DEPTH_LOG2-1:0] c,
                                                      input logic [1:0] bte);
      logic [DEPTH_LOG2-1:0] inc;
      logic [DEPTH_LOG2-1:0] mask;
      inc = c + 1'b1;
      case (bte)
         2'b01:   mask = DEPTH_LOG2'(3);
         2'b10:   mask = DEPTH_LOG2'(7);
         2'b11:   mask = DEPTH_LOG2'(15);
         default: mask = '1;
      endcase
      return (c & ~mask) | (inc & mask);
   endfunction

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < SEL_W; i++)
         lane_mask[i*8 +: 8] = {8{wishbone_sel_i[i]}};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bte_d   = bte_q;
      wait_d  = wait_q;
      oor_d   = oor_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = '0;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               cnt_d   = addr_word;
               bte_d   = wishbone_bte_i;
               oor_d   = addr_oor;
               wait_d  = 4'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? S_BEAT : S_WAIT;
            end
         end
         S_WAIT: begin
            wait_d = wait_q - 4'd1;
            if (wait_q <= 4'd1)
               state_d = S_BEAT;
         end
         S_BEAT: begin
            if (req) begin
               if (oor_q) begin
                  err_d   = 1'b1;
                  state_d = S_GAP;
               end else begin
                  ack_d = 1'b1;
                  if (wishbone_we_i)
                     mem_we = 1'b1;
                  else
                     data_d = mem[cnt_q] & lane_mask;
                  if (wishbone_cti_i == CTI_INCR) begin
                     cnt_d   = advance(cnt_q, bte_q);
                     state_d = S_BURST;
                  end else begin
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_BURST: begin
            if (req) begin
               ack_d = 1'b1;
               if (wishbone_we_i)
                  mem_we = 1'b1;
               else
                  data_d = mem[cnt_q] & lane_mask;
               cnt_d = advance(cnt_q, bte_q);
               if (wishbone_cti_i != CTI_INCR)
                  state_d = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Master abandoning the cycle cancels whatever was in flight.
      if (!wishbone_cyc_i) begin
         state_d = S_IDLE;
         ack_d   = 1'b0;
         err_d   = 1'b0;
         data_d  = '0;
         mem_we  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bte_q   <= 2'b00;
         wait_q  <= 4'd0;
         oor_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bte_q   <= bte_d;
         wait_q  <= wait_d;
         oor_q   <= oor_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int i = 0; i < SEL_W; i++)
            if (wishbone_sel_i[i])
               mem[cnt_q][i*8 +: 8] <= wishbone_data_i[i*8 +: 8];
      end
   end

   // Gating with cyc keeps ack/err from being seen once the master has let go.
   assign wishbone_ack_o  = ack_q & wishbone_cyc_i;
   assign wishbone_err_o  = err_q & wishbone_cyc_i;
   assign wishbone_data_o = data_q;

endmodule

// File: doc/wishbone_ram_burst.md
# wishbone_ram_burst

Parametrised Wishbone slave RAM: the successor to the single-beat 32-bit data RAM on the CPU's Wishbone bus. It generalises data width, depth and access latency. It adds registered-feedback incrementing bursts (CTI/BTE), linear and wrapping, and an error response for out-of-range addresses. It sits on the system Wishbone interconnect as the main instruction/data memory.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8 (8/16/32/64).
- ADDR_WIDTH, 32, byte-address bus width.
- DEPTH_LOG2, 12, log2 of memory depth in words.
- WAIT_STATES, 1, idle cycles inserted before the first ack of each cycle (0..15).
- Derived: SEL_W = DATA_WIDTH/8; OFS = log2(SEL_W); word index = addr[DEPTH_LOG2+OFS-1:OFS].

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wishbone_addr_i  in  ADDR_WIDTH  byte address.
- wishbone_data_i  in  DATA_WIDTH  write data.
- wishbone_we_i  in  1  1 = write.
- wishbone_sel_i  in  SEL_W  byte-lane enables.
- wishbone_stb_i  in  1  strobe.
- wishbone_cyc_i  in  1  bus cycle.
- wishbone_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other codes are treated as 000.
- wishbone_bte_i  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- wishbone_data_o  out  DATA_WIDTH  registered read data.
- wishbone_ack_o  out  1  transfer acknowledge.
- wishbone_err_o  out  1  error acknowledge (address out of range).

## Operation
- Request: req = stb & cyc.
- State machine states: IDLE, WAIT, BEAT, BURST, GAP.
- IDLE, on req:
  - Latch the word index into an internal address counter (cnt) and latch bte.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT; go directly to BEAT if WAIT_STATES = 0.
- WAIT: decrement the wait counter; go to BEAT when it reaches 0.
- Range check: an address is out of range if addr[ADDR_WIDTH-1:DEPTH_LOG2+OFS] != 0.
- BEAT (first transfer), in range:
  - Writes update the selected lanes of mem[cnt].
  - Reads drive data_o with mem[cnt] on selected lanes and zero on unselected lanes.
  - ack is high for this cycle.
- BEAT, out of range:
  - err is high instead of ack.
  - No memory write; data_o = 0.
  - Then go to GAP, never BURST.
- After an in-range BEAT:
  - If cti = 010: advance cnt and go to BURST.
  - Otherwise: go to GAP.
- BURST: one beat per cycle while req is high.
  - ack is high on each beat; read data and write address come from cnt.
  - addr_i is ignored after the first beat.
- Address advance (cnt):
  - Linear: cnt + 1 mod 2^DEPTH_LOG2.
  - Wrap-N: the low log2(N) bits increment mod N; the upper bits are held.
- Stall and end conditions in BURST:
  - stb low with cyc high: no ack; cnt and state are held.
  - A beat taken with cti = 111 (or any code other than 010): this is the last beat; go to GAP.
- GAP: ack, err and all state are low for one cycle, then IDLE.
- cyc low in any state: return to IDLE next cycle; no ack/err; writes already acked remain.
- Memory is uninitialised; simulation behaviour of unwritten words is X.

## Timing
- Reset values: data_o = 0, ack_o = 0, err_o = 0, state = IDLE, cnt = 0.
- rst asserted mid-burst: outputs are 0 from the next edge and no further writes occur.
- ack/err are registered. With req first sampled high at edge E0, the first ack/err is high in the cycle after edge E0+1+WAIT_STATES.
- Read data is valid in the same cycle as its ack.
- Classic back-to-back throughput: one transfer per WAIT_STATES+3 cycles (IDLE sample, waits, BEAT, GAP).
- Burst: after the first beat, one ack per cycle; zero-wait streaming while stb is held high.
- ack and err are never high together. Neither is ever high while cyc = 0 or in the cycle following reset.

## Test plan
- Classic write/read:
  - Stimulus: WAIT_STATES=1, write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 with sel=0011.
  - Required: ack exactly 3 cycles after stb; read data_o = 0x0000BEEF.
- Linear burst read:
  - Stimulus: preload words 0..7 = index×0x11; read burst at 0x8 (word 2), cti 010,010,010,111.
  - Required: data 0x22, 0x33, 0x44, 0x55 on four consecutive ack cycles, then GAP.
- Wrap-4 burst write:
  - Stimulus: write burst at word 6, bte=01, data A,B,C,D.
  - Required: words 6, 7, 4, 5 contain A, B, C, D; word 8 is unchanged.
- Mid-burst stall:
  - Stimulus: drop stb for 2 cycles between beats 2 and 3 of a linear read.
  - Required: no ack during the stall; beat 3 returns the correct next word.
- Out of range:
  - Stimulus: DEPTH_LOG2=12, write 0x55 to address 0x4000.
  - Required: err high for one cycle, ack low; a following read of 0x0000 is unchanged.
- Reset during burst:
  - Stimulus: assert rst on beat 2 of a 4-beat write.
  - Required: ack low from the next edge; only beat 1 (and beat 2 if acked) is written.
